// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding and
// requester port identifiers.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   // 2'd3 is unused; the FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESP    = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-request round-robin picker.
//   elig[1:0]  : eligible requests, indexed by port id (PORT_A / PORT_B)
//   last_grant : port id granted most recently (held by the caller)
//   gnt_vld    : at least one request is eligible
//   gnt_id     : port id to grant this cycle
// -----------------------------------------------------------------------------
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] elig,
   input  logic       last_grant,
   output logic       gnt_vld,
   output logic       gnt_id
);

   always_comb begin
      gnt_vld = |elig;
      gnt_id  = PORT_A;
      // On a tie the port that did not win last time goes first.
      if (elig[PORT_A] && elig[PORT_B]) begin
         gnt_id = ~last_grant;
      end else if (elig[PORT_B]) begin
         gnt_id = PORT_B;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises two requesters onto one single-port memory with round-robin
// arbitration. Each access is IDLE (grant) -> ACCESS (mem_enable high) ->
// RESP (registered read data valid) -> ack pulse in the following cycle.
//   clock, reset_n              : clock, asynchronous active-low reset
//   req_x/rw_x/addr_x/wdata_x   : requester command (rw 1 = read, 0 = write)
//   ack_x                       : one-cycle completion pulse
//   rdata_x                     : read result, updated only on a read ack
//   busy                        : FSM is in ACCESS or RESP
//   mem_enable/rw/addr/wdata    : registered command to the memory
//   mem_rdata                   : memory read data (high-Z when disabled)
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int N = 17,
   parameter int M = 3
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         req_a,
   input  logic         rw_a,
   input  logic [M-1:0] addr_a,
   input  logic [N-1:0] wdata_a,
   input  logic         req_b,
   input  logic         rw_b,
   input  logic [M-1:0] addr_b,
   input  logic [N-1:0] wdata_b,
   output logic         ack_a,
   output logic         ack_b,
   output logic [N-1:0] rdata_a,
   output logic [N-1:0] rdata_b,
   output logic         busy,
   output logic         mem_enable,
   output logic         mem_rw,
   output logic [M-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata
);

   state_t         state_q, state_d;
   logic           last_grant_q, last_grant_d;
   logic           owner_q, owner_d;
   logic           mem_enable_q, mem_enable_d;
   logic           mem_rw_q, mem_rw_d;
   logic [M-1:0]   mem_addr_q, mem_addr_d;
   logic [N-1:0]   mem_wdata_q, mem_wdata_d;
   logic           ack_a_q, ack_a_d;
   logic           ack_b_q, ack_b_d;
   logic [N-1:0]   rdata_a_q, rdata_a_d;
   logic [N-1:0]   rdata_b_q, rdata_b_d;

   logic [1:0]     elig;
   logic           gnt_vld;
   logic           gnt_id;

   // A request still high in its own ack cycle is stale and must not win.
   assign elig[PORT_A] = req_a & ~ack_a_q;
   assign elig[PORT_B] = req_b & ~ack_b_q;

   rr_arb2 u_rr_arb2 (
      .elig       (elig),
      .last_grant (last_grant_q),
      .gnt_vld    (gnt_vld),
      .gnt_id     (gnt_id)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      mem_enable_d = 1'b0;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      ack_a_d      = 1'b0;
      ack_b_d      = 1'b0;
      rdata_a_d    = rdata_a_q;
      rdata_b_d    = rdata_b_q;

      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d      = ACCESS;
               last_grant_d = gnt_id;
               owner_d      = gnt_id;
               mem_enable_d = 1'b1;
               // Command is captured here; later requester changes are ignored.
               if (gnt_id == PORT_A) begin
                  mem_rw_d    = rw_a;
                  mem_addr_d  = addr_a;
                  mem_wdata_d = wdata_a;
               end else begin
                  mem_rw_d    = rw_b;
                  mem_addr_d  = addr_b;
                  mem_wdata_d = wdata_b;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
         end
         RESP: begin
            // mem_rdata is only driven in this state, so it is sampled only here.
            state_d = IDLE;
            if (owner_q == PORT_A) begin
               ack_a_d = 1'b1;
               if (mem_rw_q) rdata_a_d = mem_rdata;
            end else begin
               ack_b_d = 1'b1;
               if (mem_rw_q) rdata_b_d = mem_rdata;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_B;
         owner_q      <= PORT_A;
         mem_enable_q <= 1'b0;
         mem_rw_q     <= 1'b1;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         ack_a_q      <= 1'b0;
         ack_b_q      <= 1'b0;
         rdata_a_q    <= '0;
         rdata_b_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         mem_enable_q <= mem_enable_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         ack_a_q      <= ack_a_d;
         ack_b_q      <= ack_b_d;
         rdata_a_q    <= rdata_a_d;
         rdata_b_q    <= rdata_b_d;
      end
   end

   assign busy       = (state_q == ACCESS) || (state_q == RESP);
   assign mem_enable = mem_enable_q;
   assign mem_rw     = mem_rw_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign ack_a      = ack_a_q;
   assign ack_b      = ack_b_q;
   assign rdata_a    = rdata_a_q;
   assign rdata_b    = rdata_b_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter: behavioural 8x17 memory (init value = address),
// directed scenarios, then randomized two-port rounds against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int N = 17;
   localparam int M = 3;

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic         req_a = 1'b0, req_b = 1'b0;
   logic         rw_a  = 1'b1, rw_b  = 1'b1;
   logic [M-1:0] addr_a = '0, addr_b = '0;
   logic [N-1:0] wdata_a = '0, wdata_b = '0;
   logic         ack_a, ack_b, busy, mem_enable, mem_rw;
   logic [N-1:0] rdata_a, rdata_b, mem_wdata;
   logic [M-1:0] mem_addr;
   wire  [N-1:0] mem_rdata;

   mem_arbiter #(.N(N), .M(M)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_a      (req_a),
      .rw_a       (rw_a),
      .addr_a     (addr_a),
      .wdata_a    (wdata_a),
      .req_b      (req_b),
      .rw_b       (rw_b),
      .addr_b     (addr_b),
      .wdata_b    (wdata_b),
      .ack_a      (ack_a),
      .ack_b      (ack_b),
      .rdata_a    (rdata_a),
      .rdata_b    (rdata_b),
      .busy       (busy),
      .mem_enable (mem_enable),
      .mem_rw     (mem_rw),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clock = ~clock;

   // Behavioural single-port memory: registered read, output driven only in
   // the cycle after an enabled read.
   logic [N-1:0] mem_arr [8];
   logic [N-1:0] mem_dout = '0;
   logic         mem_dvld = 1'b0;
   initial for (int i = 0; i < 8; i++) mem_arr[i] = N'(i);
   always @(posedge clock) begin
      mem_dvld <= mem_enable & mem_rw;
      if (mem_enable) begin
         if (mem_rw) mem_dout <= mem_arr[mem_addr];
         else        mem_arr[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_dvld ? mem_dout : 'z;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      req_a   = 1'b0;
      req_b   = 1'b0;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Single access on one port; returns read data, cycles to ack (-1 on
   // timeout) and number of cycles mem_enable was seen high.
   task automatic do_access(input logic port, input logic rw, input logic [M-1:0] addr,
                            input logic [N-1:0] wd, output logic [N-1:0] rd,
                            output int lat, output int en_cnt);
      lat    = -1;
      en_cnt = 0;
      rd     = '0;
      if (port == PORT_A) begin
         rw_a = rw; addr_a = addr; wdata_a = wd; req_a = 1'b1;
      end else begin
         rw_b = rw; addr_b = addr; wdata_b = wd; req_b = 1'b1;
      end
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (mem_enable) en_cnt++;
         if ((port == PORT_A) ? ack_a : ack_b) begin
            lat = c;
            rd  = (port == PORT_A) ? rdata_a : rdata_b;
            break;
         end
      end
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   // Reference-model state and scratch variables
   logic [N-1:0] ref_mem [8];
   logic [N-1:0] rd;
   int           lat, en_cnt, ack_both, ack_seen;
   int           cyc_q[$];
   logic         port_q[$];
   logic         m_last, first, p;
   logic [N-1:0] mdl_rd_a, mdl_rd_b, got_a, got_b;
   int           mode, idx, exp_cyc_a, exp_cyc_b, got_cyc_a, got_cyc_b;
   logic         use_a, use_b, ra_rw, rb_rw;
   logic [M-1:0] ra_addr, rb_addr;
   logic [N-1:0] ra_wd, rb_wd;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) ref_mem[i] = N'(i);

      // ---- reset values ----
      do_reset();
      check("rst_ack_a",      32'(ack_a),      32'(0));
      check("rst_ack_b",      32'(ack_b),      32'(0));
      check("rst_busy",       32'(busy),       32'(0));
      check("rst_mem_enable", 32'(mem_enable), 32'(0));
      check("rst_mem_rw",     32'(mem_rw),     32'(1));
      check("rst_mem_addr",   32'(mem_addr),   32'(0));
      check("rst_mem_wdata",  32'(mem_wdata),  32'(0));
      check("rst_rdata_a",    32'(rdata_a),    32'(0));
      check("rst_rdata_b",    32'(rdata_b),    32'(0));

      // ---- read address 5 on port A ----
      do_access(PORT_A, 1'b1, 3'd5, '0, rd, lat, en_cnt);
      check("t1_lat",    32'(lat),    32'(3));
      check("t1_rdata",  32'(rd),     32'(5));
      check("t1_en_cnt", 32'(en_cnt), 32'(1));
      tick();
      check("t1_ack_pulse", 32'(ack_a), 32'(0));

      // ---- write A then read B ----
      do_access(PORT_A, 1'b0, 3'd2, 17'h1ABCD, rd, lat, en_cnt);
      ref_mem[2] = 17'h1ABCD;
      check("t2_wr_lat",    32'(lat),    32'(3));
      check("t2_wr_en_cnt", 32'(en_cnt), 32'(1));
      check("t2_wr_hold_a", 32'(rdata_a), 32'(5));
      tick();
      do_access(PORT_B, 1'b1, 3'd2, '0, rd, lat, en_cnt);
      check("t2_rd_lat",    32'(lat),    32'(3));
      check("t2_rd_data",   32'(rd),     32'(17'h1ABCD));
      check("t2_rd_en_cnt", 32'(en_cnt), 32'(1));
      tick();

      // ---- simultaneous requests from reset, held ----
      do_reset();
      rw_a = 1'b1; addr_a = 3'd1; rw_b = 1'b1; addr_b = 3'd3;
      req_a = 1'b1; req_b = 1'b1;
      ack_both = 0;
      cyc_q.delete();
      port_q.delete();
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (ack_a && ack_b) ack_both = 1;
         if (ack_a) begin cyc_q.push_back(c); port_q.push_back(PORT_A); end
         if (ack_b) begin cyc_q.push_back(c); port_q.push_back(PORT_B); end
      end
      req_a = 1'b0; req_b = 1'b0;
      check("t3_n_acks",   32'(cyc_q.size()), 32'(5));
      check("t3_ack_both", 32'(ack_both),     32'(0));
      for (int i = 0; i < 5; i++) begin
         if (i < cyc_q.size()) begin
            check($sformatf("t3_ack%0d_cycle", i), 32'(cyc_q[i]), 32'(3 * (i + 1)));
            check($sformatf("t3_ack%0d_port", i), 32'(port_q[i]), 32'(i % 2));
         end
      end
      check("t3_rdata_a", 32'(rdata_a), 32'(1));
      check("t3_rdata_b", 32'(rdata_b), 32'(3));
      tick();
      check("t3_idle_busy", 32'(busy), 32'(0));

      // ---- req_a held through the ack cycle ----
      rw_a = 1'b1; addr_a = 3'd4; req_a = 1'b1;
      tick(); tick(); tick();
      check("t4_ack", 32'(ack_a), 32'(1));
      tick();
      check("t4_no_dup_grant", 32'(mem_enable), 32'(0));
      req_a = 1'b0;
      tick();
      check("t4_dropped_enable", 32'(mem_enable), 32'(0));
      check("t4_dropped_busy",   32'(busy),       32'(0));
      req_a = 1'b1;
      tick(); tick(); tick();
      check("t4b_ack", 32'(ack_a), 32'(1));
      tick();
      check("t4b_no_dup_grant", 32'(mem_enable), 32'(0));
      tick();
      check("t4b_regrant", 32'(mem_enable), 32'(1));
      req_a = 1'b0;
      tick(); tick();
      check("t4b_ack2", 32'(ack_a), 32'(1));
      tick();

      // ---- reset during ACCESS abandons the write ----
      rw_a = 1'b0; addr_a = 3'd7; wdata_a = 17'h0F0F; req_a = 1'b1;
      tick();
      check("t5_access_enable", 32'(mem_enable), 32'(1));
      #2;
      reset_n = 1'b0;
      #1;
      req_a = 1'b0;
      check("t5_rst_enable",  32'(mem_enable), 32'(0));
      check("t5_rst_busy",    32'(busy),       32'(0));
      check("t5_rst_mem_rw",  32'(mem_rw),     32'(1));
      check("t5_rst_addr",    32'(mem_addr),   32'(0));
      check("t5_rst_wdata",   32'(mem_wdata),  32'(0));
      check("t5_rst_rdata_a", 32'(rdata_a),    32'(0));
      check("t5_rst_rdata_b", 32'(rdata_b),    32'(0));
      tick(); tick();
      reset_n = 1'b1;
      ack_seen = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (ack_a || ack_b) ack_seen = 1;
      end
      check("t5_no_ack", 32'(ack_seen), 32'(0));
      do_access(PORT_A, 1'b1, 3'd7, '0, rd, lat, en_cnt);
      check("t5_read7", 32'(rd), 32'(7));
      tick();

      // ---- addr_b changed after grant ----
      rw_b = 1'b1; addr_b = 3'd1; req_b = 1'b1;
      tick();
      check("t6_latched_addr", 32'(mem_addr), 32'(1));
      addr_b = 3'd6;
      tick(); tick();
      req_b = 1'b0;
      check("t6_ack",   32'(ack_b),   32'(1));
      check("t6_rdata", 32'(rdata_b), 32'(1));
      tick();

      // ---- randomized rounds vs. transaction-level model ----
      do_reset();
      m_last   = PORT_B;
      mdl_rd_a = '0;
      mdl_rd_b = '0;
      for (int r = 0; r < 40; r++) begin
         mode    = $urandom_range(0, 2);
         use_a   = (mode != 1);
         use_b   = (mode != 0);
         ra_rw   = 1'($urandom_range(0, 1));
         rb_rw   = 1'($urandom_range(0, 1));
         ra_addr = M'($urandom);
         rb_addr = M'($urandom);
         ra_wd   = N'($urandom);
         rb_wd   = N'($urandom);

         // Model: order of service, memory effect, expected ack cycles.
         if (use_a && use_b) first = ~m_last;
         else if (use_a)     first = PORT_A;
         else                first = PORT_B;
         idx = 0; exp_cyc_a = 0; exp_cyc_b = 0;
         for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : ~first;
            if (p == PORT_A && use_a) begin
               idx++; exp_cyc_a = 3 * idx; m_last = PORT_A;
               if (ra_rw) mdl_rd_a = ref_mem[ra_addr];
               else       ref_mem[ra_addr] = ra_wd;
            end else if (p == PORT_B && use_b) begin
               idx++; exp_cyc_b = 3 * idx; m_last = PORT_B;
               if (rb_rw) mdl_rd_b = ref_mem[rb_addr];
               else       ref_mem[rb_addr] = rb_wd;
            end
         end

         rw_a = ra_rw; addr_a = ra_addr; wdata_a = ra_wd; req_a = use_a;
         rw_b = rb_rw; addr_b = rb_addr; wdata_b = rb_wd; req_b = use_b;
         got_cyc_a = 0; got_cyc_b = 0; en_cnt = 0; ack_both = 0;
         got_a = '0; got_b = '0;
         for (int c = 1; c <= 20; c++) begin
            tick();
            if (mem_enable) en_cnt++;
            if (ack_a && ack_b) ack_both = 1;
            if (ack_a) begin got_cyc_a = c; got_a = rdata_a; req_a = 1'b0; end
            if (ack_b) begin got_cyc_b = c; got_b = rdata_b; req_b = 1'b0; end
            if ((!use_a || got_cyc_a != 0) && (!use_b || got_cyc_b != 0)) break;
         end
         req_a = 1'b0; req_b = 1'b0;
         check($sformatf("rnd%0d_cyc_a", r), 32'(got_cyc_a), 32'(exp_cyc_a));
         check($sformatf("rnd%0d_cyc_b", r), 32'(got_cyc_b), 32'(exp_cyc_b));
         check($sformatf("rnd%0d_en_cnt", r), 32'(en_cnt), 32'(int'(use_a) + int'(use_b)));
         check($sformatf("rnd%0d_ack_both", r), 32'(ack_both), 32'(0));
         if (use_a) check($sformatf("rnd%0d_ack_rdata_a", r), 32'(got_a), 32'(mdl_rd_a));
         if (use_b) check($sformatf("rnd%0d_ack_rdata_b", r), 32'(got_b), 32'(mdl_rd_b));
         tick();
         check($sformatf("rnd%0d_hold_rdata_a", r), 32'(rdata_a), 32'(mdl_rd_a));
         check($sformatf("rnd%0d_hold_rdata_b", r), 32'(rdata_b), 32'(mdl_rd_b));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
